warp_pixel_fetch: RTL

WARP_PIXEL_FETCH -- requirements
Module: warp_pixel_fetch

---
 rtl/warp_pkg.sv | 15 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/warp_pixel_fetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/warp_pkg.sv
// Shared defaults and request-FSM state type for the warp pixel fetch block.
package warp_pkg;

    localparam int WARP_DATA_WIDTH  = 8;
    localparam int WARP_COORD_WIDTH = 16;
    localparam int WARP_ADDR_WIDTH  = 20;
    localparam int WARP_DEPTH       = 8;
    localparam int WARP_FILL_VALUE  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full flags and a combinational head read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt, cnt_nxt;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop)
            cnt_nxt = cnt + (AW+1)'(1);
        else if (!do_push && do_pop)
            cnt_nxt = cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
        end
    end

    // Storage is pure data: no reset, only the pointers qualify it.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/warp_pixel_fetch.sv
// Fetches source pixels for warped coordinates, substituting a fill value out of bounds.
// Optional WARP_FETCH_STATS_EN adds a saturating oob_count output.
module warp_pixel_fetch
    import warp_pkg::*;
#(
    parameter int DATA_WIDTH  = WARP_DATA_WIDTH,
    parameter int COORD_WIDTH = WARP_COORD_WIDTH,
    parameter int ADDR_WIDTH  = WARP_ADDR_WIDTH,
    parameter int DEPTH       = WARP_DEPTH,
    parameter int FILL_VALUE  = WARP_FILL_VALUE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   coord_valid,
    output logic                   coord_ready,
    input  logic [COORD_WIDTH-1:0] src_x,
    input  logic [COORD_WIDTH-1:0] src_y,
    input  logic [COORD_WIDTH-1:0] src_width,
    input  logic [COORD_WIDTH-1:0] src_height,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   mem_rd_req,
    input  logic                   mem_rd_gnt,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic                   mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [DATA_WIDTH-1:0]  pix_data,
    output logic                   pix_fill
`ifdef WARP_FETCH_STATS_EN
    ,
    output logic [31:0]            oob_count
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    req_state_t              state_p0, state_p1;
    logic [ADDR_WIDTH-1:0]   addr_p0, addr_p1, coord_addr;
    logic [CNT_W-1:0]        out_cnt, rd_pend;
    logic                    accept, coord_oob, ib_accept, pix_pop, rd_issue, rd_take;
    logic                    ord_empty, ord_full, ord_head, dat_empty, dat_full;
    logic [DATA_WIDTH-1:0]   dat_head;

    // Address arithmetic is modular, so working at ADDR_WIDTH equals full width then truncate.
    assign coord_addr = base_addr
                      + ADDR_WIDTH'(src_y) * ADDR_WIDTH'(src_width)
                      + ADDR_WIDTH'(src_x);

    assign coord_oob   = (src_x >= src_width) || (src_y >= src_height);
    assign coord_ready = !rst && !ord_full && (out_cnt < CNT_W'(DEPTH))
                         && ((state_p1 == ST_IDLE) || mem_rd_gnt);
    assign accept      = coord_valid && coord_ready;
    assign ib_accept   = accept && !coord_oob;
    assign rd_issue    = mem_rd_req && mem_rd_gnt;
    assign rd_take     = mem_rd_valid && (rd_pend != '0) && !dat_full;
    assign pix_pop     = pix_valid && pix_ready;
    assign mem_rd_addr = addr_p1;

    always_comb begin
        state_p0   = state_p1;
        addr_p0    = addr_p1;
        mem_rd_req = 1'b0;
        case (state_p1)
            ST_IDLE: begin
                if (ib_accept) begin
                    state_p0 = ST_REQ;
                    addr_p0  = coord_addr;
                end
            end
            ST_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_gnt) begin
                    if (ib_accept)
                        addr_p0 = coord_addr;
                    else
                        state_p0 = ST_IDLE;
                end
            end
            default: state_p0 = ST_IDLE;
        endcase
    end

    // Stage p1: request state, held address and occupancy counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= ST_IDLE;
            addr_p1  <= '0;
            out_cnt  <= '0;
            rd_pend  <= '0;
        end else begin
            state_p1 <= state_p0;
            addr_p1  <= addr_p0;
            case ({accept, pix_pop})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
            case ({rd_issue, rd_take})
                2'b10:   rd_pend <= rd_pend + CNT_W'(1);
                2'b01:   rd_pend <= rd_pend - CNT_W'(1);
                default: rd_pend <= rd_pend;
            endcase
        end
    end

    sync_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data (coord_oob),
        .pop     (pix_pop),
        .rd_data (ord_head),
        .empty   (ord_empty),
        .full    (ord_full)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rd_take),
        .wr_data (mem_rd_data),
        .pop     (pix_pop && !ord_head),
        .rd_data (dat_head),
        .empty   (dat_empty),
        .full    (dat_full)
    );

    always_comb begin
        pix_valid = !ord_empty && (ord_head || !dat_empty);
        pix_data  = '0;
        pix_fill  = 1'b0;
        if (pix_valid) begin
            pix_fill = ord_head;
            pix_data = ord_head ? DATA_WIDTH'(FILL_VALUE) : dat_head;
        end
    end

`ifdef WARP_FETCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            oob_count <= '0;
        else if (accept && coord_oob)
            oob_count <= sat_inc(oob_count);
    end
`endif

endmodule
